// File: rtl/hilo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hilo_pkg
// Description : Shared types and constants for the HI/LO multiply controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hilo_pkg;

  // Controller sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } hilo_state_t;

  // regsel_EX encodings that read the HI/LO pair
  localparam logic [1:0] REGSEL_HI = 2'b01;
  localparam logic [1:0] REGSEL_LO = 2'b10;

  // True when the EX-stage instruction is an MFHI or MFLO
  function automatic logic is_hilo_read(input logic [1:0] sel);
    return (sel == REGSEL_HI) || (sel == REGSEL_LO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_add_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_step
// Description : One radix-2 shift-add iteration. The accumulator holds a
//               WIDTH+1-bit upper half (carry included) above a WIDTH-bit
//               lower half that initially carries the multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]  acc_i,
  input  logic [WIDTH-1:0]  mcand_i,
  output logic [2*WIDTH:0]  acc_o
);

  logic [WIDTH:0] w_upper;

  // Conditionally add the multiplicand into the upper half, then shift right
  always_comb begin
    w_upper = acc_i[2*WIDTH:WIDTH];
    if (acc_i[0]) begin
      w_upper = w_upper + {1'b0, mcand_i};
    end
    acc_o = {1'b0, w_upper, acc_i[WIDTH-1:1]};
  end

endmodule
`default_nettype wire

// File: rtl/hilo_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hilo_mult_ctrl
// Description : Iterative MULT/MULTU controller owning the HI/LO pair. Runs a
//               WIDTH-cycle shift-add on operand magnitudes, applies the sign
//               in a final FIX cycle and holds the pipeline for conflicting
//               HI/LO reads or a second multiply while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_mult_ctrl
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       regsel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

  hilo_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [2*WIDTH-1:0] w_prod, w_result;
  logic [2*WIDTH:0]   w_step;

  // Operand magnitudes; -2^(WIDTH-1) negates to itself, which is the correct
  // unsigned magnitude
  assign w_mag_a = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign w_mag_b = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;

  // Signed result over the full 2*WIDTH product; negating zero stays zero
  assign w_prod   = acc_q[2*WIDTH-1:0];
  assign w_result = neg_q ? -w_prod : w_prod;

  shift_add_step #(.WIDTH(WIDTH)) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .acc_o   (w_step)
  );

  // Next-state and datapath sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = w_mag_a;
          acc_d   = {{(WIDTH+1){1'b0}}, w_mag_b};
          neg_d   = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          cnt_d   = CNT_INIT;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = w_step;
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        {hi_d, lo_d} = w_result;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and HI/LO registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;
  assign busy  = (state_q != IDLE);
  assign stall = busy & (start | is_hilo_read(regsel));

endmodule
`default_nettype wire

// File: tb/tb_hilo_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_mult_ctrl
// Description : Self-checking bench for hilo_mult_ctrl (WIDTH = 32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_mult_ctrl;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       regsel;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic             done;

  int n_cmp  = 0;
  int n_fail = 0;

  hilo_mult_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .regsel    (regsel),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .stall     (stall),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one multiply in cycle T and return the cycle offset at which done appears
  task automatic run_mult(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
    @(negedge clk);
    start = 1'b1; is_signed = s; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; op_a = '0; op_b = '0;
    lat = 1;
    #1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      #1;
    end
  endtask

  initial begin
    int lat;
    int done_seen;

    vecs[0]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{1'b1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3]  = '{1'b0, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000};
    vecs[4]  = '{1'b1, 32'h00000000, 32'hFFFFFFFB, 32'h00000000, 32'h00000000};
    vecs[5]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[6]  = '{1'b1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
    vecs[7]  = '{1'b0, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    vecs[8]  = '{1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    vecs[9]  = '{1'b1, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000};
    vecs[10] = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[11] = '{1'b1, 32'h00000005, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFEC};

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0; regsel = 2'b00;

    // Reset held two cycles
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_hi", 64'(hi), 64'h0);
    check("reset_lo", 64'(lo), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_stall", 64'(stall), 64'h0);
    check("reset_done", 64'(done), 64'h0);

    // Table of directed products
    for (int i = 0; i < 12; i++) begin
      run_mult(vecs[i].s, vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd34);
      check($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
      check($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
      @(negedge clk);
      #1;
      check($sformatf("vec%0d_done_pulse", i), 64'(done), 64'h0);
      check($sformatf("vec%0d_idle", i), 64'(busy), 64'h0);
    end

    // MFHI held from T+5 stalls until the new product is visible
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; op_a = 32'hFFFFFFFF; op_b = 32'h00000002;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      start = 1'b0;
      regsel = (c >= 5) ? 2'b01 : ((c == 2) ? 2'b11 : 2'b00);
      #1;
      if (c == 1) check("mfhi_busy_t1", 64'(busy), 64'h1);
      if (c == 2) check("regsel11_no_stall", 64'(stall), 64'h0);
      if (c >= 5 && c <= 33) check($sformatf("mfhi_stall_t%0d", c), 64'(stall), 64'h1);
      if (c == 34) begin
        check("mfhi_stall_release", 64'(stall), 64'h0);
        check("mfhi_done", 64'(done), 64'h1);
        check("mfhi_hi_new", 64'(hi), 64'h1);
        check("mfhi_lo_new", 64'(lo), 64'hFFFFFFFE);
      end
    end
    @(negedge clk);
    regsel = 2'b00;

    // Second start held from T+3; operands changing mid-flight must not corrupt the first
    start = 1'b1; is_signed = 1'b1; op_a = 32'hFFFFFFFD; op_b = 32'h00000007;
    for (int c = 1; c <= 68; c++) begin
      @(negedge clk);
      if (c <= 2 || c >= 35) begin
        start = 1'b0; op_a = '0; op_b = '0;
      end else begin
        start = 1'b1; is_signed = 1'b0; op_a = 32'h00010000; op_b = 32'h00010000;
      end
      #1;
      if (c >= 3 && c <= 33) check($sformatf("b2b_stall_t%0d", c), 64'(stall), 64'h1);
      if (c == 34) begin
        check("b2b_stall_release", 64'(stall), 64'h0);
        check("b2b_first_done", 64'(done), 64'h1);
        check("b2b_first_hi", 64'(hi), 64'hFFFFFFFF);
        check("b2b_first_lo", 64'(lo), 64'hFFFFFFEB);
      end
      if (c == 35) check("b2b_second_accepted", 64'(busy), 64'h1);
      if (c == 67) check("b2b_no_early_done", 64'(done), 64'h0);
      if (c == 68) begin
        check("b2b_second_done", 64'(done), 64'h1);
        check("b2b_second_hi", 64'(hi), 64'h1);
        check("b2b_second_lo", 64'(lo), 64'h0);
      end
    end

    // Reset asserted in cycle T+10 aborts the multiply
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF;
    done_seen = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      rst = (c == 10);
      #1;
      if (c == 11) begin
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_hi", 64'(hi), 64'h0);
        check("abort_lo", 64'(lo), 64'h0);
        check("abort_done", 64'(done), 64'h0);
      end
      if (c >= 11 && done) done_seen++;
    end
    check("abort_no_done_pulse", 64'(done_seen), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
